// File: rtl/display_serial_rx.sv
// Receives the 3-wire 7-segment serial stream (data, shift clock, latch).
// Each frame is deserialised and committed as a parallel word, with framing errors flagged.
module display_serial_rx #(
  parameter int FRAME_BITS            = 48,
  parameter int SYS_CLK_HZ            = 50_000_000,
  parameter int SHIFT_CLK_HZ          = 1_000_000,
  parameter int TIMEOUT_SHIFT_PERIODS = 16,
  localparam int CNT_W                = $clog2(FRAME_BITS + 2)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic                  i_serial_data,
  input  logic                  i_serial_clk,
  input  logic                  i_serial_latch,
  output logic [FRAME_BITS-1:0] o_frame,
  output logic                  o_frame_stb,
  output logic [1:0]            o_err,
  output logic                  o_err_stb,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_bit_count
);

  localparam int TO_CYCLES = (SYS_CLK_HZ / SHIFT_CLK_HZ) * TIMEOUT_SHIFT_PERIODS;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            data_sync_reg;
  logic [2:0]            clk_sync_reg, latch_sync_reg;
  logic                  data_reg, clk_edge_reg, latch_edge_reg;
  logic [FRAME_BITS-1:0] sr_reg, sr_next, frame_reg, frame_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [TO_W-1:0]       to_reg, to_next;
  logic [1:0]            err_reg, err_next;
  logic                  frame_stb_reg, frame_stb_next, err_stb_reg, err_stb_next;

  // Synchronisers and edge detectors run regardless of i_en so re-enabling never sees a false edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_sync_reg  <= '0;
      clk_sync_reg   <= '0;
      latch_sync_reg <= '0;
      data_reg       <= 1'b0;
      clk_edge_reg   <= 1'b0;
      latch_edge_reg <= 1'b0;
    end else begin
      data_sync_reg  <= {data_sync_reg[0], i_serial_data};
      clk_sync_reg   <= {clk_sync_reg[1:0], i_serial_clk};
      latch_sync_reg <= {latch_sync_reg[1:0], i_serial_latch};
      data_reg       <= data_sync_reg[1];
      clk_edge_reg   <= clk_sync_reg[1] & ~clk_sync_reg[2];
      latch_edge_reg <= latch_sync_reg[1] & ~latch_sync_reg[2];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= IDLE;
      sr_reg        <= '0;
      frame_reg     <= '0;
      cnt_reg       <= '0;
      to_reg        <= '0;
      err_reg       <= '0;
      frame_stb_reg <= 1'b0;
      err_stb_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sr_reg        <= sr_next;
      frame_reg     <= frame_next;
      cnt_reg       <= cnt_next;
      to_reg        <= to_next;
      err_reg       <= err_next;
      frame_stb_reg <= frame_stb_next;
      err_stb_reg   <= err_stb_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sr_next        = sr_reg;
    frame_next     = frame_reg;
    cnt_next       = cnt_reg;
    to_next        = to_reg;
    err_next       = err_reg;
    frame_stb_next = 1'b0;
    err_stb_next   = 1'b0;
    if (i_en) begin
      if (clk_edge_reg) begin
        sr_next    = {sr_reg[FRAME_BITS-2:0], data_reg};
        to_next    = '0;
        state_next = SHIFT;
        if (state_reg == IDLE)
          cnt_next = CNT_W'(1);
        else if (cnt_reg != CNT_MAX)
          cnt_next = cnt_reg + CNT_W'(1);
      end else if (state_reg == SHIFT) begin
        if (to_reg == TO_LAST) begin
          err_next     = 2'd3;
          err_stb_next = 1'b1;
          cnt_next     = '0;
          to_next      = '0;
          state_next   = IDLE;
        end else begin
          to_next = to_reg + TO_W'(1);
        end
      end
      // Latch is judged on the post-shift count so a coincident final clock edge still counts.
      if (latch_edge_reg && state_next == SHIFT) begin
        if (cnt_next == CNT_FULL) begin
          frame_next     = sr_next;
          err_next       = 2'd0;
          frame_stb_next = 1'b1;
        end else begin
          err_next     = (cnt_next < CNT_FULL) ? 2'd1 : 2'd2;
          err_stb_next = 1'b1;
        end
        cnt_next   = '0;
        to_next    = '0;
        state_next = IDLE;
      end
    end
  end

  assign o_frame     = frame_reg;
  assign o_frame_stb = frame_stb_reg;
  assign o_err       = err_reg;
  assign o_err_stb   = err_stb_reg;
  assign o_busy      = (state_reg == SHIFT);
  assign o_bit_count = cnt_reg;

endmodule

// File: tb/tb_display_serial_rx.sv
// Scoreboard bench for display_serial_rx: stimulus pushes expected commits/errors with their
// strobe cycle, and a negedge monitor pops and compares whenever a strobe appears.
module tb_display_serial_rx;

  localparam int FB = 48;
  localparam int CW = $clog2(FB + 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b1;
  logic          sdata = 1'b0, sclk = 1'b0, slatch = 1'b0;
  logic [FB-1:0] frame;
  logic          frame_stb, err_stb, busy;
  logic [1:0]    err;
  logic [CW-1:0] bit_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise = 0;

  typedef struct {
    bit            is_err;
    logic [FB-1:0] frame;
    logic [1:0]    err;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  display_serial_rx dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en),
    .i_serial_data(sdata), .i_serial_clk(sclk), .i_serial_latch(slatch),
    .o_frame(frame), .o_frame_stb(frame_stb), .o_err(err), .o_err_stb(err_stb),
    .o_busy(busy), .o_bit_count(bit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push(input bit is_err, input logic [FB-1:0] f, input logic [1:0] e, input int c);
    exp_t x;
    x.is_err = is_err; x.frame = f; x.err = e; x.cyc = c;
    sb.push_back(x);
  endfunction

  always @(negedge clk) begin
    if (rst_n && (frame_stb || err_stb)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe frame_stb=%0b err_stb=%0b required none (cycle %0d)", frame_stb, err_stb, cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("frame_stb", 64'(frame_stb), 64'(!x.is_err));
        chk("err_stb", 64'(err_stb), 64'(x.is_err));
        chk("frame", 64'(frame), 64'(x.frame));
        chk("err", 64'(err), 64'(x.err));
        chk("strobe_cycle", 64'(cyc), 64'(x.cyc));
        chk("busy_after", 64'(busy), 64'd0);
        chk("count_after", 64'(bit_count), 64'd0);
        $display("txn: %s frame=%012h err=%0d cycle=%0d", x.is_err ? "err  " : "frame", frame, err, cyc);
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk); sdata = b;
    repeat (10) @(negedge clk);
    sclk = 1'b1; last_rise = cyc;
    repeat (25) @(negedge clk);
    sclk = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic send_n(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_latch(input bit is_err, input logic [FB-1:0] f, input logic [1:0] e);
    @(negedge clk); slatch = 1'b1;
    push(is_err, f, e, cyc + 4);
    repeat (10) @(negedge clk);
    slatch = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f1, f2, f3, f4, lng;
    f1  = 64'h0000_A53C_F00F_817E;
    f2  = 64'h0000_1234_5678_9ABC;
    f3  = 64'h0000_FEDC_BA98_7654;
    f4  = 64'h0000_0F1E_2D3C_4B5A;
    lng = {14'd0, 2'b11, 48'h0000_0000_0001};

    #1 rst_n = 1'b0;
    #20;
    chk("reset_frame", 64'(frame), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_count", 64'(bit_count), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame
    send_n(f1, 48);
    chk("good_count_before_latch", 64'(bit_count), 64'd48);
    do_latch(1'b0, f1[FB-1:0], 2'd0);

    // Short frame, then recovery
    send_n(f2, 47);
    do_latch(1'b1, f1[FB-1:0], 2'd1);
    send_n(f2, 48);
    do_latch(1'b0, f2[FB-1:0], 2'd0);

    // Long frame: count saturates at FB+1
    send_n(lng, 50);
    chk("long_count", 64'(bit_count), 64'd49);
    do_latch(1'b1, f2[FB-1:0], 2'd2);

    // Timeout after 20 bits
    send_n(f3, 20);
    chk("timeout_busy_mid", 64'(busy), 64'd1);
    push(1'b1, f2[FB-1:0], 2'd3, last_rise + 804);
    repeat (900) @(negedge clk);
    chk("timeout_count", 64'(bit_count), 64'd0);
    chk("timeout_busy", 64'(busy), 64'd0);
    send_n(f3, 48);
    do_latch(1'b0, f3[FB-1:0], 2'd0);

    // Enable gating, then coincident final clock and latch edge
    send_n(f4 >> 1, 47);
    @(negedge clk); en = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    repeat (10) @(negedge clk);
    chk("en_low_count", 64'(bit_count), 64'd47);
    chk("en_low_busy", 64'(busy), 64'd1);
    en = 1'b1;
    repeat (10) @(negedge clk);
    sdata = f4[0];
    repeat (10) @(negedge clk);
    sclk = 1'b1; slatch = 1'b1;
    push(1'b0, f4[FB-1:0], 2'd0, cyc + 4);
    repeat (25) @(negedge clk);
    sclk = 1'b0; slatch = 1'b0;
    repeat (20) @(negedge clk);

    // Asynchronous reset mid-frame
    send_n(f1, 10);
    chk("pre_reset_count", 64'(bit_count), 64'd10);
    chk("pre_reset_frame", 64'(frame), 64'(f4[FB-1:0]));
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async_reset_frame", 64'(frame), 64'd0);
    chk("async_reset_count", 64'(bit_count), 64'd0);
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_err", 64'(err), 64'd0);
    sdata = 1'b0; sclk = 1'b0; slatch = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_frame", 64'(frame), 64'd0);
    chk("post_reset_count", 64'(bit_count), 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_serial_rx.md
Name: display_serial_rx

Overview:
- Downstream stage of the clock top level. Receives the 3-wire 7-segment serial stream (data, shift clock, latch) that normally drives the external shift-register chain.
- Deserialises each frame and presents the last complete frame as a parallel word.
- Flags framing errors (short frame, long frame, stalled frame).
- Used as on-chip loopback and readback checker, and as the bench-side display model.

Parameters:
- FRAME_BITS, 48, bits per frame (6 digits x 8 bits: 7 segments + dp).
- SYS_CLK_HZ, 50_000_000, i_clk frequency.
- SHIFT_CLK_HZ, 1_000_000, nominal serial clock rate.
- TIMEOUT_SHIFT_PERIODS, 16, idle serial-clock periods mid-frame before abort; timeout cycles = (SYS_CLK_HZ/SHIFT_CLK_HZ)*TIMEOUT_SHIFT_PERIODS (default 800).

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_en  in  1  enable; low freezes receiver state.
- i_serial_data  in  1  serial data, asynchronous to i_clk.
- i_serial_clk  in  1  shift clock; data sampled on its rising edge.
- i_serial_latch  in  1  latch; rising edge commits frame.
- o_frame  out  FRAME_BITS  last committed frame; first bit received is at MSB.
- o_frame_stb  out  1  one-cycle pulse when o_frame is updated.
- o_err  out  2  last frame status: 0 ok, 1 short, 2 long, 3 timeout.
- o_err_stb  out  1  one-cycle pulse when o_err is set nonzero.
- o_busy  out  1  high while in SHIFT state.
- o_bit_count  out  $clog2(FRAME_BITS+2)  bits received in current frame.

Behaviour:
- Reset (async assert, sync-to-clock release not required inside block):
  - All outputs 0; state IDLE.
  - Shift register, counters and synchronisers cleared.
- Input conditioning:
  - Each of the three inputs passes a 2-flop synchroniser, then a third flop for edge detect.
  - Pin rising edge to detected edge: 3 i_clk cycles.
  - Data is captured from the synchronised data stage in the same cycle the clk edge is detected.
  - Data must be stable >=3 i_clk cycles around the serial clk rising edge.
- i_en low:
  - Synchronisers keep running, so no false edge on re-enable.
  - Detected edges are ignored; state, counters and outputs hold; strobes held 0.
- State IDLE:
  - On clk edge: shift in bit, bit_count=1, timeout counter cleared, go to SHIFT.
  - Latch edge in IDLE with bit_count 0: ignored, no error.
- State SHIFT:
  - Each clk edge: shift register {sr[FRAME_BITS-2:0], data}; bit_count increments, saturating at FRAME_BITS+1; timeout counter cleared.
  - Beyond FRAME_BITS edges, shifting continues, so the register holds the last FRAME_BITS bits.
  - Timeout counter increments each enabled cycle without a clk edge.
- Latch edge in SHIFT:
  - bit_count==FRAME_BITS: o_frame<=sr, o_frame_stb=1, o_err<=0.
  - bit_count<FRAME_BITS: o_err<=1, o_err_stb=1, o_frame unchanged.
  - bit_count>FRAME_BITS: o_err<=2, o_err_stb=1, o_frame unchanged.
  - In all three cases: bit_count<=0, go to IDLE.
- Timeout: counter reaching timeout cycles in SHIFT gives o_err<=3, o_err_stb=1, bit_count<=0, IDLE, o_frame unchanged.
- Strobe latency: strobes assert the cycle after the latch/timeout is detected, i.e. 4 i_clk cycles after the latch pin rises.
- Simultaneous clk and latch edge detected in one cycle: the bit is shifted and counted first, and the latch check uses the updated count and register.
- Falling edges of clk and latch have no effect.
- o_busy = (state==SHIFT).
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.

Test Plan:
- Reset: hold i_reset_n=0 mid-stream, asynchronously -> all outputs 0 within the same cycle, no strobe after release.
- Good frame: send 48 bits 0xA5_3C_F0_0F_81_7E at 1 MHz, then latch -> o_frame=48'hA53CF00F817E, o_frame_stb one pulse 4 cycles after latch rise, o_err=0, o_busy back to 0.
- Short frame: 47 bits then latch -> o_err=1, o_err_stb pulse, o_frame keeps previous value; next good frame -> o_err=0.
- Long frame: 50 bits (first two 1, rest 0x000000000001) then latch -> o_err=2, o_frame unchanged, o_bit_count reads 49 before latch.
- Timeout: 20 bits then stop for 801 cycles -> o_err=3 at cycle 800 after last edge, bit_count 0, IDLE; following good frame accepted.
- Enable/simultaneity: i_en=0 during 5 clk edges -> count unchanged; then drive 48th clk and latch rising on the same i_clk edge -> frame accepted, o_err=0.
